// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB PWM block: LED channel indices, default
// geometry and the full-scale duty helper.
package rgb_pwm_pkg;

   // Bit positions of each colour within the led bus.
   localparam int CH_R = 2;
   localparam int CH_G = 1;
   localparam int CH_B = 0;

   // Defaults give roughly 1 kHz PWM from a 12 MHz clock.
   localparam int DEF_WIDTH = 8;
   localparam int DEF_PRESC = 47;

   // Full-scale duty code. It is also the period length in ticks.
   function automatic int pwm_max(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/pwm_chan.sv
// One colour channel: pending and active duty registers, the counter
// compare, and the registered, polarity-corrected LED drive.
module pwm_chan
   import rgb_pwm_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             pend,
   input  logic             apply,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] duty,
   output logic             led
);

   // Pin level that leaves the LED dark.
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [WIDTH-1:0] pend_duty;
   logic [WIDTH-1:0] act;
   logic             on;

   // Shared counter below the active duty means the channel is lit.
   assign on = (cnt < act);

   // Capture on load. At a period boundary a same-cycle load wins over the
   // older pending value, so the newest request is never delayed a period.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_duty <= '0;
         act       <= '0;
         led       <= POL;
      end else begin
         if (load) begin
            pend_duty <= duty;
         end
         if (apply) begin
            if (load) begin
               act <= duty;
            end else if (pend) begin
               act <= pend_duty;
            end
         end
         led <= on ^ POL;
      end
   end

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel PWM driver for the tri-colour LED. Holds the shared
// prescaler and period counter, the pending-update flag and the
// period_start pulse. New duties are double-buffered and take effect only
// when the counter wraps, so a period is never torn.
module rgb_pwm
   import rgb_pwm_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESC      = DEF_PRESC,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] duty_r,
   input  logic [WIDTH-1:0] duty_g,
   input  logic [WIDTH-1:0] duty_b,
   input  logic             load,
   output logic             pend,
   output logic             period_start,
   output logic [2:0]       led
);

   // Prescaler needs at least one bit even when it is a pass-through.
   localparam int               PW     = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0]    PLAST  = PW'(PRESC - 1);
   localparam logic [WIDTH-1:0] MAX    = WIDTH'(pwm_max(WIDTH));
   localparam logic [WIDTH-1:0] CLAST  = MAX - WIDTH'(1);

   logic [PW-1:0]    pcnt;
   logic [WIDTH-1:0] cnt;
   logic             tick;
   logic             apply;

   assign tick  = (pcnt == PLAST);
   // Last tick of the period: counter wraps and pending duties go live.
   assign apply = tick && (cnt == CLAST);

   // Prescaler: one PWM tick every PRESC clock cycles.
   always_ff @(posedge clk) begin
      if (rst || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   // Period counter runs 0..MAX-1 so a MAX duty stays lit for the whole period.
   always_ff @(posedge clk) begin
      if (rst || apply) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

   // Pending flag: set by load, cleared when the boundary consumes it.
   always_ff @(posedge clk) begin
      if (rst || apply) begin
         pend <= 1'b0;
      end else if (load) begin
         pend <= 1'b1;
      end
   end

   // Marks the first cycle of each new period (none after reset).
   always_ff @(posedge clk) begin
      if (rst) begin
         period_start <= 1'b0;
      end else begin
         period_start <= apply;
      end
   end

   pwm_chan #(.WIDTH(WIDTH), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_r (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .pend  (pend),
      .apply (apply),
      .cnt   (cnt),
      .duty  (duty_r),
      .led   (led[CH_R])
   );

   pwm_chan #(.WIDTH(WIDTH), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_g (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .pend  (pend),
      .apply (apply),
      .cnt   (cnt),
      .duty  (duty_g),
      .led   (led[CH_G])
   );

   pwm_chan #(.WIDTH(WIDTH), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_b (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .pend  (pend),
      .apply (apply),
      .cnt   (cnt),
      .duty  (duty_b),
      .led   (led[CH_B])
   );

endmodule

// File: tb/tb_rgb_pwm.sv
// Directed bench for rgb_pwm. Main instance: WIDTH=4, PRESC=2, active-low
// (period 30 clk). Second instance: WIDTH=4, PRESC=1, active-high
// (period 15 clk). Lit time is counted over whole-period windows and
// compared with hand-computed values.
module tb_rgb_pwm;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, load;
   logic [3:0] duty_r, duty_g, duty_b;
   logic       pend, period_start;
   logic [2:0] led;

   logic       rst2, load2;
   logic [3:0] duty2_r, duty2_g, duty2_b;
   logic       pend2, period_start2;
   logic [2:0] led2;

   rgb_pwm #(.WIDTH(4), .PRESC(2), .ACTIVE_LOW(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .duty_r       (duty_r),
      .duty_g       (duty_g),
      .duty_b       (duty_b),
      .load         (load),
      .pend         (pend),
      .period_start (period_start),
      .led          (led)
   );

   rgb_pwm #(.WIDTH(4), .PRESC(1), .ACTIVE_LOW(0)) dut2 (
      .clk          (clk),
      .rst          (rst2),
      .duty_r       (duty2_r),
      .duty_g       (duty2_g),
      .duty_b       (duty2_b),
      .load         (load2),
      .pend         (pend2),
      .period_start (period_start2),
      .led          (led2)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;
   int lit_r, lit_g, lit_b, ps_cnt, pend_cnt;
   int lit2_r, lit2_g, lit2_b, ps2_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      lit_r = 0; lit_g = 0; lit_b = 0; ps_cnt = 0; pend_cnt = 0;
      lit2_r = 0; lit2_g = 0; lit2_b = 0; ps2_cnt = 0;
   endtask

   // Advance n cycles, accumulating lit cycles, pulses and pending cycles.
   task automatic sample_n(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if (led[2] == 1'b0) lit_r++;
         if (led[1] == 1'b0) lit_g++;
         if (led[0] == 1'b0) lit_b++;
         if (period_start)   ps_cnt++;
         if (pend)           pend_cnt++;
         if (led2[2] == 1'b1) lit2_r++;
         if (led2[1] == 1'b1) lit2_g++;
         if (led2[0] == 1'b1) lit2_b++;
         if (period_start2)   ps2_cnt++;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; load = 1'b1;
      duty_r = 4'd15; duty_g = 4'd15; duty_b = 4'd15;
      rst2 = 1'b1; load2 = 1'b0;
      duty2_r = 4'd0; duty2_g = 4'd0; duty2_b = 4'd0;
      clr();

      // 1. reset dominates load
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_led", 32'(led), 32'd7);
         chk("rst_pend", 32'(pend), 32'd0);
         chk("rst_ps", 32'(period_start), 32'd0);
      end
      chk("rst2_led", 32'(led2), 32'd0);

      // 2. basic duty, loaded in the first period after reset
      rst = 1'b0;
      duty_r = 4'd4; duty_g = 4'd0; duty_b = 4'd15; load = 1'b1;
      clr();
      sample_n(1);
      load = 1'b0;
      chk("load_pend", 32'(pend), 32'd1);
      sample_n(28);
      chk("p0_lit_r", lit_r, 0);
      chk("p0_lit_g", lit_g, 0);
      chk("p0_lit_b", lit_b, 0);
      chk("p0_ps", ps_cnt, 0);
      chk("p0_pend", pend_cnt, 29);
      sample_n(1);
      chk("wrap_ps", 32'(period_start), 32'd1);
      chk("wrap_pend", 32'(pend), 32'd0);
      chk("wrap_led", 32'(led), 32'd7);
      clr();
      sample_n(30);
      chk("p1_lit_r", lit_r, 8);
      chk("p1_lit_g", lit_g, 0);
      chk("p1_lit_b", lit_b, 30);
      chk("p1_ps", ps_cnt, 1);
      chk("p1_ps_last", 32'(period_start), 32'd1);
      chk("p1_pend", pend_cnt, 0);

      // 3. deferred update at cnt=7
      clr();
      sample_n(14);
      duty_r = 4'd10; load = 1'b1;
      sample_n(1);
      load = 1'b0;
      chk("defer_pend", 32'(pend), 32'd1);
      sample_n(15);
      chk("defer_keep_r", lit_r, 8);
      chk("defer_ps", ps_cnt, 1);
      chk("defer_pend_cnt", pend_cnt, 15);
      clr();
      sample_n(30);
      chk("defer_new_r", lit_r, 20);
      chk("defer_new_g", lit_g, 0);
      chk("defer_new_b", lit_b, 30);
      chk("defer_new_pend", pend_cnt, 0);

      // 4a. two loads before a wrap: last write wins
      clr();
      duty_r = 4'd3; load = 1'b1;
      sample_n(1);
      load = 1'b0;
      sample_n(5);
      duty_r = 4'd9; load = 1'b1;
      sample_n(1);
      load = 1'b0;
      sample_n(23);
      chk("ovw_old_r", lit_r, 20);
      chk("ovw_pend_cnt", pend_cnt, 29);
      chk("ovw_ps", ps_cnt, 1);
      clr();
      sample_n(30);
      chk("ovw_new_r", lit_r, 18);

      // 4b. load exactly on the apply cycle
      clr();
      sample_n(29);
      chk("coll_pre_r", lit_r, 18);
      chk("coll_pre_pend", pend_cnt, 0);
      duty_r = 4'd6; load = 1'b1;
      sample_n(1);
      load = 1'b0;
      chk("coll_ps", 32'(period_start), 32'd1);
      chk("coll_pend", 32'(pend), 32'd0);
      clr();
      sample_n(30);
      chk("coll_r", lit_r, 12);
      chk("coll_pend_cnt", pend_cnt, 0);
      chk("coll_ps_cnt", ps_cnt, 1);

      // 5. reset mid-period with an update pending
      duty_r = 4'd12; load = 1'b1;
      sample_n(1);
      load = 1'b0;
      chk("mid_pend", 32'(pend), 32'd1);
      sample_n(9);
      chk("mid_pre_led", 32'(led), 32'd2);
      rst = 1'b1;
      step();
      chk("mid_rst_led", 32'(led), 32'd7);
      chk("mid_rst_pend", 32'(pend), 32'd0);
      chk("mid_rst_ps", 32'(period_start), 32'd0);
      rst = 1'b0;
      clr();
      sample_n(30);
      chk("post_rst_lit", lit_r + lit_g + lit_b, 0);
      chk("post_rst_ps", ps_cnt, 1);
      chk("post_rst_pend", pend_cnt, 0);
      clr();
      sample_n(30);
      chk("post_rst2_lit", lit_r + lit_g + lit_b, 0);
      chk("post_rst2_ps", ps_cnt, 1);

      // 6. active-high, prescaler of one, G=1
      chk("p6_rst_led", 32'(led2), 32'd0);
      chk("p6_rst_pend", 32'(pend2), 32'd0);
      rst2 = 1'b0;
      duty2_g = 4'd1; load2 = 1'b1;
      clr();
      sample_n(1);
      load2 = 1'b0;
      chk("p6_pend", 32'(pend2), 32'd1);
      sample_n(14);
      chk("p6_first_g", lit2_g, 0);
      chk("p6_first_ps", ps2_cnt, 1);
      chk("p6_wrap_ps", 32'(period_start2), 32'd1);
      clr();
      sample_n(1);
      chk("p6_on_led", 32'(led2), 32'd2);
      sample_n(14);
      chk("p6_g", lit2_g, 1);
      chk("p6_r", lit2_r, 0);
      chk("p6_b", lit2_b, 0);
      chk("p6_ps", ps2_cnt, 1);
      clr();
      sample_n(15);
      chk("p6_g_again", lit2_g, 1);
      chk("p6_ps_again", ps2_cnt, 1);

      // ---------------- report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rgb_pwm.md
Name: rgb_pwm

Overview:
- Downstream stage of the switch-to-RGB path. Turns three per-channel brightness codes into PWM drive for the on-board tri-colour LED, so colours mix at 2^WIDTH-1 intensity levels instead of plain on/off.
- Sits between the colour-select logic and the LED pins.
- Duty updates are double-buffered and only take effect at a period boundary, so the LED never shows a torn period.

Parameters:
- WIDTH, 8: duty/counter width. Period = 2^WIDTH-1 ticks (MAX).
- PRESC, 47: clk cycles per PWM tick. At 12 MHz with defaults this gives ≈1 kHz PWM. Legal range ≥1.
- ACTIVE_LOW, 1: 1 = LED pin driven 0 to light (board default); 0 = active-high.

Ports:
- clk  in  1  system clock, 12 MHz
- rst  in  1  synchronous, active-high reset
- duty_r  in  WIDTH  red brightness, 0 = off, MAX = always on
- duty_g  in  WIDTH  green brightness
- duty_b  in  WIDTH  blue brightness
- load  in  1  one-cycle strobe: capture duty_r/g/b into pending registers
- pend  out  1  high while captured duties are waiting for the next period start
- period_start  out  1  one-cycle pulse on the cycle the PWM counter wraps to 0
- led  out  3  LED drive: led[2]=R, led[1]=G, led[0]=B; polarity per ACTIVE_LOW

Behaviour:
- Prescaler
  - pcnt counts 0..PRESC-1.
  - tick=1 on the cycle pcnt==PRESC-1, then pcnt wraps to 0.
  - PRESC=1 means tick every cycle.
- PWM counter
  - cnt advances by 1 on tick.
  - On tick with cnt==MAX-1, cnt wraps to 0. That is the apply cycle.
  - cnt never reaches MAX.
- period_start: registered, high exactly on the first cycle cnt==0 of each period.
- Pending path
  - load=1 captures all three duties into pend_* and sets pend=1.
  - A repeated load before apply overwrites pend_* (last write wins).
- Apply cycle
  - If pend=1: act_* <= pend_*, pend <= 0.
  - If load=1 in the same cycle: act_* <= the live duty_* inputs and pend <= 0 (the new load wins, no extra period of delay).
  - If pend=0 and no load: act_* unchanged.
- Output
  - on[i] = (cnt < act_i), evaluated every cycle.
  - led registered from on[] one cycle later: led[i] <= on[i] XOR ACTIVE_LOW.
  - Resulting high time per period = act × PRESC clk cycles.
  - Duty 0 never lights; duty MAX is lit for the whole period.
- Arithmetic
  - All compares are unsigned and WIDTH bits.
  - No truncation paths; pcnt width is clog2(PRESC), minimum 1.
- Reset (sync, dominant over load)
  - pcnt=0, cnt=0, act_*=0, pend_*=0, pend=0, period_start=0.
  - led = all off: 3'b111 when ACTIVE_LOW, else 3'b000.
  - First period starts on the cycle after rst deasserts; there is no period_start pulse for that first period.
- Reset mid-period discards the pending update and turns the LED off within one cycle.
- Each channel is independent. All three channels share cnt, so they switch on together at cnt=0.

Decomposition:
- Package rgb_pwm_pkg holds:
  - channel index constants CH_R=2, CH_G=1, CH_B=0
  - default WIDTH and PRESC
  - function for MAX (2^WIDTH-1)
- Sub-module pwm_chan is instantiated ×3. Each instance holds:
  - one channel's pend and act registers
  - the cnt<act compare
  - the output flop with polarity
- Top level keeps the prescaler, cnt, pend flag and period_start.

Test Plan:
(Bench uses WIDTH=4, PRESC=2, ACTIVE_LOW=1, so MAX=15 and period = 30 clk.)
1. Reset: hold rst 3 cycles with load=1 → led=3'b111, pend=0, period_start=0 throughout. After release, led stays 3'b111 for a full period.
2. Basic duty: load R=4, G=0, B=15 → pend=1 until wrap. Next period: led[2] low for 8 clk; led[1] always high; led[0] low for all 30 clk. period_start pulses every 30 clk.
3. Deferred update: mid-period (cnt=7) load R=10 → current period keeps R=4. pend=1 until wrap, then R is low for 20 clk per period.
4. Overwrite and collision:
   - Two loads before a wrap (R=3 then R=9) → R=9 applied.
   - Load R=6 exactly on the apply cycle → R=6 applied that period and pend=0 the cycle after.
5. Mid-operation reset: rst asserted at cnt=5 with pend=1 → next cycle led=3'b111, pend=0. After release, nothing is applied until a new load.
6. Polarity/prescale: ACTIVE_LOW=0, PRESC=1, duty G=1 → led[1] high for exactly 1 clk every 15 clk.
